// File: rtl/lfsr_cfg_sequencer.sv
// Programs an LFSR core over AXI-Lite (seed, taps, clear-stop, start), counts stream beats, then stops it.
// Back-to-back writes with no idle cycle between B and the next AW; each channel waits on its own ready/valid.
module lfsr_cfg_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             cmd_start,
  input  logic             cmd_abort,
  input  logic [7:0]       cfg_seed,
  input  logic [7:0]       cfg_taps,
  input  logic [CNT_W-1:0] cfg_count,
  output logic [3:0]       m_axi_awaddr,
  output logic             m_axi_awvalid,
  input  logic             m_axi_awready,
  output logic [31:0]      m_axi_wdata,
  output logic             m_axi_wvalid,
  input  logic             m_axi_wready,
  input  logic [1:0]       m_axi_bresp,
  input  logic             m_axi_bvalid,
  output logic             m_axi_bready,
  input  logic             s_axis_tvalid,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] beats_seen
);

  typedef enum logic [3:0] {
    IDLE, W_SEED, W_TAPS, W_CLRSTOP, W_START, RUN, W_STOP, W_CLRSTART, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       seed_q, seed_d;
  logic [7:0]       taps_q, taps_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic [CNT_W-1:0] beats_inc;
  logic             aw_done_q, aw_done_d;
  logic             w_done_q, w_done_d;
  logic             err_q, err_d;
  logic             is_wr;
  logic             b_bad;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= IDLE;
      seed_q    <= '0;
      taps_q    <= '0;
      count_q   <= '0;
      beats_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      seed_q    <= seed_d;
      taps_q    <= taps_d;
      count_q   <= count_d;
      beats_q   <= beats_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_q     <= err_d;
    end
  end

  assign err        = err_q;
  assign beats_seen = beats_q;

  always_comb begin
    state_d      = state_q;
    seed_d       = seed_q;
    taps_d       = taps_q;
    count_d      = count_q;
    beats_d      = beats_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    err_d        = err_q;
    beats_inc    = beats_q + CNT_W'(1);
    b_bad        = 1'b0;
    is_wr        = 1'b0;
    m_axi_awaddr = 4'h0;
    m_axi_wdata  = 32'h0;

    // Address/data are a pure function of the state, so they stay stable while valid.
    case (state_q)
      W_SEED:     begin is_wr = 1'b1; m_axi_awaddr = 4'h8; m_axi_wdata = {24'h0, seed_q}; end
      W_TAPS:     begin is_wr = 1'b1; m_axi_awaddr = 4'hC; m_axi_wdata = {24'h0, taps_q}; end
      W_CLRSTOP:  begin is_wr = 1'b1; m_axi_awaddr = 4'h4; m_axi_wdata = 32'h0; end
      W_START:    begin is_wr = 1'b1; m_axi_awaddr = 4'h0; m_axi_wdata = 32'h1; end
      W_STOP:     begin is_wr = 1'b1; m_axi_awaddr = 4'h4; m_axi_wdata = 32'h1; end
      W_CLRSTART: begin is_wr = 1'b1; m_axi_awaddr = 4'h0; m_axi_wdata = 32'h0; end
      default:    ;
    endcase

    m_axi_awvalid = is_wr && !aw_done_q;
    m_axi_wvalid  = is_wr && !w_done_q;
    m_axi_bready  = is_wr && aw_done_q && w_done_q;
    busy          = (state_q != IDLE) && (state_q != DONE);
    done          = (state_q == DONE);

    if (is_wr) begin
      if (m_axi_awvalid && m_axi_awready) aw_done_d = 1'b1;
      if (m_axi_wvalid && m_axi_wready)   w_done_d  = 1'b1;
      if (m_axi_bready && m_axi_bvalid) begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        b_bad     = (m_axi_bresp != 2'b00);
        if (b_bad) err_d = 1'b1;
        // A failed setup write jumps straight to the stop writes so the core is never left running.
        case (state_q)
          W_SEED:    state_d = b_bad ? W_STOP : W_TAPS;
          W_TAPS:    state_d = b_bad ? W_STOP : W_CLRSTOP;
          W_CLRSTOP: state_d = b_bad ? W_STOP : W_START;
          W_START:   state_d = b_bad ? W_STOP : RUN;
          W_STOP:    state_d = W_CLRSTART;
          default:   state_d = DONE;
        endcase
      end
    end

    case (state_q)
      IDLE: begin
        if (cmd_start) begin
          seed_d  = cfg_seed;
          taps_d  = cfg_taps;
          count_d = cfg_count;
          err_d   = 1'b0;
          beats_d = '0;
          state_d = W_SEED;
        end
      end
      RUN: begin
        if (s_axis_tvalid) begin
          beats_d = beats_inc;
          if ((count_q != '0) && (beats_inc == count_q)) state_d = W_STOP;
        end
        if (cmd_abort) state_d = W_STOP;
      end
      DONE:    state_d = IDLE;
      default: ;
    endcase
  end

endmodule
